// File: rtl/keystream_session_arbiter.sv
// rtl/keystream_session_arbiter.sv - round-robin session arbiter sharing one keystream core
module keystream_session_arbiter #(
  parameter int NREQ   = 2,
  parameter int LEN_W  = 4,
  parameter int WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*8-1:0]        req_seed,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  output logic [NREQ-1:0]          req_ready,
  output logic [((NREQ <= 2) ? 1 : $clog2(NREQ))-1:0] grant_id,
  output logic                     busy,
  input  logic                     din_valid,
  input  logic [7:0]               din,
  output logic                     din_ready,
  output logic                     dout_valid,
  output logic [7:0]               dout,
  output logic [((NREQ <= 2) ? 1 : $clog2(NREQ))-1:0] dout_id,
  output logic                     dout_last,
  input  logic                     dout_ready,
  output logic                     done,
  output logic                     core_load,
  output logic [7:0]               core_seed,
  output logic                     core_step,
  input  logic                     core_bit
);

  localparam int ID_W = (NREQ <= 2) ? 1 : $clog2(NREQ);
  localparam int WC_W = (WARMUP <= 2) ? 1 : $clog2(WARMUP);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WARM, S_GEN, S_WAIT_IN, S_OUT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             grant;
  logic [7:0]       sel_seed;
  logic [LEN_W-1:0] sel_len;
  logic [7:0]       seed_q;
  logic [7:0]       ks;
  logic [LEN_W-1:0] remaining;
  logic [WC_W-1:0]  warm_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       dout_q;
  logic [ID_W-1:0]  dout_id_q;
  logic             dout_last_q;

  // 0x00 and 0xFF are command codes on the core side, so they are nudged off
  function automatic logic [7:0] sanitize(input logic [7:0] s);
    if (s == 8'h00)      return 8'h01;
    else if (s == 8'hFF) return 8'hFE;
    else                 return s;
  endfunction

  // Round-robin search: first requesting index at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign grant = (state == S_IDLE) && found && !rst;

  // Mux the winner's seed and length with constant slices
  always_comb begin
    sel_seed = 8'h00;
    sel_len  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == ID_W'(k)) begin
        sel_seed = req_seed[8*k +: 8];
        sel_len  = req_len[LEN_W*k +: LEN_W];
      end
    end
  end

  // One-hot acceptance pulse to the winning requester
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; the core is locked to one session until DONE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (grant) state_nx = (sel_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:    state_nx = (WARMUP > 0) ? S_WARM : S_GEN;
      S_WARM:    if (warm_cnt == WARM_LAST) state_nx = S_GEN;
      S_GEN:     if (bit_cnt == 3'd7) state_nx = S_WAIT_IN;
      S_WAIT_IN: if (din_valid) state_nx = S_OUT;
      S_OUT:     if (dout_ready) state_nx = dout_last_q ? S_DONE : S_GEN;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Session bookkeeping, keystream assembly and the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      owner       <= '0;
      seed_q      <= 8'h00;
      remaining   <= '0;
      warm_cnt    <= '0;
      bit_cnt     <= 3'd0;
      ks          <= 8'h00;
      dout_q      <= 8'h00;
      dout_id_q   <= '0;
      dout_last_q <= 1'b0;
    end else begin
      if (grant) begin
        owner     <= pick;
        ptr       <= ID_W'((int'(pick) + 1) % NREQ);
        seed_q    <= sanitize(sel_seed);
        remaining <= sel_len;
      end
      warm_cnt <= (state == S_WARM) ? warm_cnt + 1'b1 : '0;
      bit_cnt  <= (state == S_GEN) ? bit_cnt + 3'd1 : 3'd0;
      if (state == S_GEN) ks <= {ks[6:0], core_bit};
      if (state == S_WAIT_IN && din_valid) begin
        dout_q      <= din ^ ks;
        dout_id_q   <= owner;
        dout_last_q <= (remaining == LEN_W'(1));
      end
      if (state == S_OUT && dout_ready) remaining <= remaining - 1'b1;
    end
  end

  assign grant_id   = owner;
  assign busy       = grant || (state != S_IDLE);
  assign din_ready  = (state == S_WAIT_IN);
  assign dout_valid = (state == S_OUT);
  assign dout       = dout_q;
  assign dout_id    = dout_id_q;
  assign dout_last  = dout_last_q;
  assign done       = (state == S_DONE);
  assign core_load  = (state == S_LOAD);
  assign core_seed  = (state == S_LOAD) ? seed_q : 8'h00;
  assign core_step  = (state == S_WARM) || (state == S_GEN);

endmodule

// File: doc/keystream_session_arbiter.md
Name: keystream_session_arbiter

Overview:
Shares one trivium-lite keystream core between NREQ requesters. Each requester opens a session with a seed and a byte count. The arbiter grants sessions round-robin and locks the core for the whole session. For each session it loads the seed, runs warm-up steps, then collects 8 keystream bits per byte and XORs them with the granted requester's data bytes. It sits between the requester-side ports and the core's load/step/bit interface.

Parameters:
NREQ, 2, number of requesters (2..8)
LEN_W, 4, width of the per-session byte count
WARMUP, 8, core steps run and discarded after each seed load (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  session request, one bit per requester
req_seed  in  NREQ*8  per-requester seed; requester i uses bits [8i+7:8i]
req_len  in  NREQ*LEN_W  per-requester byte count
req_ready  out  NREQ  one-hot grant pulse; session accepted
grant_id  out  $clog2(NREQ) (min 1)  owner of the current session
busy  out  1  high from the grant cycle through the done cycle
din_valid  in  1  data byte from the granted requester
din  in  8  plaintext/ciphertext byte
din_ready  out  1  byte accepted
dout_valid  out  1  result byte valid
dout  out  8  din XOR keystream byte
dout_id  out  $clog2(NREQ) (min 1)  owner of dout
dout_last  out  1  final byte of the session
dout_ready  in  1  result accepted
done  out  1  one-cycle session-complete pulse
core_load  out  1  one-cycle seed-load strobe
core_seed  out  8  seed presented with core_load
core_step  out  1  advance the core one bit
core_bit  in  1  current keystream bit; sampled on cycles where core_step=1

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer = 0.
  - FSM in IDLE; keystream, length and data registers cleared.
- Reset asserted mid-session abandons the session immediately. No done pulse is produced.
- FSM states and transitions:
  - IDLE:
    - If any req_valid, choose the first set bit starting at the pointer and wrapping.
    - Drive req_ready[g]=1 combinationally this cycle.
    - Latch seed, len and g. Set pointer = (g+1) mod NREQ.
    - If len == 0, go to DONE. Otherwise go to LOAD.
  - LOAD:
    - core_load=1 for one cycle, with core_seed = sanitized seed.
    - Go to WARM if WARMUP > 0, else GEN.
  - WARM: core_step=1 for exactly WARMUP cycles; bits discarded. Then go to GEN.
  - GEN:
    - core_step=1 for exactly 8 cycles.
    - Shift ks <= {ks[6:0], core_bit}, so the first bit ends up in the MSB.
    - Then go to WAIT_IN.
  - WAIT_IN:
    - din_ready=1.
    - On din_valid, register dout = din ^ ks, dout_id = owner, dout_last = (remaining == 1).
    - Go to OUT.
  - OUT:
    - dout_valid=1; dout, dout_id and dout_last held stable.
    - On dout_ready: decrement remaining.
    - If this was the last byte, go to DONE; otherwise go to GEN.
  - DONE: done=1 for one cycle; busy still 1. Then go to IDLE.
- Seed sanitizing (0x00 and 0xFF are core command codes):
  - 0x00 -> 0x01
  - 0xFF -> 0xFE
  - Any other value passes unchanged.
- core_step is 0 in every state except WARM and GEN. Stalls in WAIT_IN or OUT do not advance the core.
- No preemption: req_valid is ignored outside IDLE. Requests from any requester stay pending until a later IDLE.
- A requester dropping req_valid after its grant does not affect its session.
- din and dout belong to the grant_id owner only. grant_id is held from the grant until the next grant.
- Minimum timing per byte: 8 GEN + 1 WAIT_IN + 1 OUT = 10 cycles.
- Session overhead: 1 grant + 1 LOAD + WARMUP + 1 DONE cycles.
- The length counter is LEN_W bits. Byte count is exact for len in 1..2^LEN_W-1, with no wrap.

Test Plan:
- After reset, req_valid=2'b11 with len 1 each -> req_ready=01, session, done; then req_ready=10. Repeating with both valid again grants requester 0 first, so grants alternate.
- Seeds 0x00, 0xFF and 0x3C -> core_seed 0x01, 0xFE and 0x3C respectively, each with a single core_load pulse.
- len=3, core model drives core_bit=1, din=0x0F each byte -> dout=0xF0 three times, dout_last only on the third byte. core_step is high for exactly WARMUP+24 cycles; done pulses once.
- len=0 -> req_ready pulse, done the next cycle, no core_load, no core_step, no dout_valid.
- dout_ready held low 5 cycles in OUT, din_valid held low 4 cycles in WAIT_IN -> dout stable, core_step=0 throughout, byte sequence unchanged versus the no-stall run.
- rst pulsed mid-GEN of a len=2 session -> next cycle all outputs 0, no done pulse. After release, with req_valid=11, requester 0 is granted first.
